// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light controllers and their benches.
//   GREEN / YELLOW / RED : 2-bit lamp encodings driven onto La / Lb
//   tl_state_e           : controller state encoding
//   max3                 : constant helper used to size the phase counter
package tl_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    typedef enum logic [2:0] {
        S_AG = 3'd0,
        S_AY = 3'd1,
        S_AR = 3'd2,
        S_BG = 3'd3,
        S_BY = 3'd4,
        S_BR = 3'd5
    } tl_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase timer: counts clocks spent in the current controller state.
//   clk     : system clock
//   reset_n : asynchronous active-low reset, clears the count
//   clr     : synchronous clear; the next count is 0
//   cnt     : current count, saturates at all-ones
module tl_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tl_cntr_timed.sv
// Two-street traffic-light controller with minimum/maximum green, yellow
// and optional all-red clearance timing. Lamps are decoded from the state
// register only.
//   clk       : system clock
//   reset_n   : asynchronous active-low reset (forces A green, B red)
//   Ta, Tb    : traffic present on street A / B, already synchronised
//   La, Lb    : lamp drive for street A / B (GREEN/YELLOW/RED encodings)
//   dbg_state : current state encoding, for observation only
module tl_cntr_timed
    import tl_pkg::*;
#(
    parameter int MIN_GREEN_CYC = 4,
    parameter int MAX_GREEN_CYC = 8,
    parameter int YELLOW_CYC    = 2,
    parameter int ALLRED_CYC    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Ta,
    input  logic       Tb,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [2:0] dbg_state
);

    localparam int CNT_W = $clog2(max3(MAX_GREEN_CYC, YELLOW_CYC, ALLRED_CYC) + 1);

    // Thresholds compared against the phase count (count is 0 on the first
    // clock of a state, so "lasts N clocks" means exit when cnt == N-1).
    localparam logic [CNT_W-1:0] MIN_M1    = CNT_W'(MIN_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_M1    = CNT_W'(MAX_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_CYC - 1);
    localparam bit               SKIP_AR   = (ALLRED_CYC == 0);

    if (MIN_GREEN_CYC < 1 || MAX_GREEN_CYC < MIN_GREEN_CYC ||
        YELLOW_CYC < 1 || ALLRED_CYC < 0) begin : g_param_check
        $error("tl_cntr_timed: illegal timing parameters");
    end

    tl_state_e        state_q;
    tl_state_e        state_d;
    logic [CNT_W-1:0] cnt;
    logic             clr;
    logic [1:0]       la_d;
    logic [1:0]       lb_d;

    tl_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .cnt     (cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_AG;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. Green exit: own street empty after the minimum, or the
    // cross street waiting at the maximum; either one leads to yellow.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_AG: if ((cnt >= MIN_M1 && !Ta) || (cnt >= MAX_M1 && Tb)) state_d = S_AY;
            S_AY: if (cnt == YELLOW_M1) state_d = SKIP_AR ? S_BG : S_AR;
            S_AR: if (cnt == ALLRED_M1) state_d = S_BG;
            S_BG: if ((cnt >= MIN_M1 && !Tb) || (cnt >= MAX_M1 && Ta)) state_d = S_BY;
            S_BY: if (cnt == YELLOW_M1) state_d = SKIP_AR ? S_AG : S_BR;
            S_BR: if (cnt == ALLRED_M1) state_d = S_AG;
            default: state_d = S_AG;
        endcase
    end

    // The phase count restarts on every state change.
    assign clr = (state_d != state_q);

    // Lamp decode; unknown encodings show red on both streets for the single
    // clock before recovery.
    always_comb begin
        la_d = RED;
        lb_d = RED;
        case (state_q)
            S_AG: la_d = GREEN;
            S_AY: la_d = YELLOW;
            S_BG: lb_d = GREEN;
            S_BY: lb_d = YELLOW;
            default: ;
        endcase
    end

    assign La        = la_d;
    assign Lb        = lb_d;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tl_cntr_timed.sv
module tb_tl_cntr_timed;
  import tl_pkg::*;

  typedef struct packed {
    logic       ta;
    logic       tb;
    logic [1:0] la;
    logic [1:0] lb;
  } vec_t;

  localparam logic [3:0] AG = {GREEN, RED};
  localparam logic [3:0] AY = {YELLOW, RED};
  localparam logic [3:0] RR = {RED, RED};
  localparam logic [3:0] BG = {RED, GREEN};
  localparam logic [3:0] BY = {RED, YELLOW};

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       Ta = 1'b0;
  logic       Tb = 1'b0;
  logic [1:0] la1, lb1, la2, lb2;
  logic [2:0] dbg1, dbg2;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] exp2_q[$];
  vec_t       vecs[$];

  // clock / reset
  always #2 clk = ~clk;

  tl_cntr_timed u_dut (
    .clk(clk), .reset_n(reset_n), .Ta(Ta), .Tb(Tb),
    .La(la1), .Lb(lb1), .dbg_state(dbg1)
  );

  tl_cntr_timed #(
    .MIN_GREEN_CYC(4), .MAX_GREEN_CYC(8), .YELLOW_CYC(1), .ALLRED_CYC(0)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .Ta(Ta), .Tb(Tb),
    .La(la2), .Lb(lb2), .dbg_state(dbg2)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got La=%b Lb=%b, want La=%b Lb=%b",
               name, $time, act[3:2], act[1:0], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic chk_excl(input string name, input logic [1:0] la, input logic [1:0] lb);
    checks++;
    if (la != RED && lb != RED) begin
      errors++;
      $display("FAIL %s at %0t: both lamps non-red La=%b Lb=%b", name, $time, la, lb);
    end
  endtask

  // Drive inputs, take one edge, then compare whatever the scoreboard expects.
  task automatic step(input string name, input logic ta, input logic tb);
    Ta = ta;
    Tb = tb;
    @(posedge clk);
    #1;
    chk_excl({name, "_excl"}, la1, lb1);
    if (exp_q.size() > 0) chk(name, {la1, lb1}, exp_q.pop_front());
    if (exp2_q.size() > 0) begin
      chk({name, "_d2"}, {la2, lb2}, exp2_q.pop_front());
      checks++;
      if (la2 == RED && lb2 == RED) begin
        errors++;
        $display("FAIL %s_d2_noallred at %0t: got La=%b Lb=%b, want not both red",
                 name, $time, la2, lb2);
      end
    end
  endtask

  // Assert reset away from an edge, check the asynchronous lamp state,
  // then release at a falling edge with the given inputs applied.
  task automatic do_reset(input string name, input logic ta_rst, input logic tb_rst,
                          input logic ta_rel, input logic tb_rel);
    @(negedge clk);
    Ta = ta_rst;
    Tb = tb_rst;
    reset_n = 1'b0;
    #1;
    chk({name, "_async"}, {la1, lb1}, AG);
    chk({name, "_async_d2"}, {la2, lb2}, AG);
    @(posedge clk);
    #1;
    chk({name, "_held"}, {la1, lb1}, AG);
    @(negedge clk);
    Ta = ta_rel;
    Tb = tb_rel;
    reset_n = 1'b1;
  endtask

  task automatic run_table(input string name, input bit to_dut2);
    foreach (vecs[i]) begin
      if (to_dut2) exp2_q.push_back({vecs[i].la, vecs[i].lb});
      else         exp_q.push_back({vecs[i].la, vecs[i].lb});
      step(name, vecs[i].ta, vecs[i].tb);
    end
    vecs.delete();
  endtask

  logic [3:0] pat14[14];
  logic [3:0] pat22[22];
  logic [3:0] pat10[10];

  initial begin
    // Expected lamps after each edge following reset release.
    pat14 = '{AG, AG, AG, AY, AY, RR, BG, BG, BG, BG, BY, BY, RR, AG};
    pat22 = '{AG, AG, AG, AG, AG, AG, AG, AY, AY, RR,
              BG, BG, BG, BG, BG, BG, BG, BG, BY, BY, RR, AG};
    pat10 = '{AG, AG, AG, AY, BG, BG, BG, BG, BY, AG};

    // 1: A occupied, B empty -> A green indefinitely
    do_reset("s1", 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) vecs.push_back({1'b1, 1'b0, AG});
    run_table("s1_hold", 1'b0);

    // 2: Ta drops one clock after release
    do_reset("s2", 1'b1, 1'b0, 1'b1, 1'b0);
    vecs.push_back({1'b1, 1'b0, AG});
    vecs.push_back({1'b0, 1'b0, AG});
    vecs.push_back({1'b0, 1'b0, AG});
    vecs.push_back({1'b0, 1'b0, AY});
    vecs.push_back({1'b0, 1'b0, AY});
    vecs.push_back({1'b0, 1'b0, RR});
    vecs.push_back({1'b0, 1'b0, BG});
    run_table("s2_drop", 1'b0);

    // 3: both occupied -> max-green alternation, 3 full cycles
    do_reset("s3", 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 66; i++) vecs.push_back({1'b1, 1'b1, pat22[i % 22]});
    run_table("s3_max", 1'b0);

    // 4: both empty -> 14-clock cycle
    do_reset("s4", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 28; i++) vecs.push_back({1'b0, 1'b0, pat14[i % 14]});
    run_table("s4_idle", 1'b0);

    // 5: reset during the second clock of B yellow
    do_reset("s5a", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) vecs.push_back({1'b0, 1'b0, pat14[i]});
    run_table("s5_to_by", 1'b0);
    do_reset("s5_mid_by", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) vecs.push_back({1'b0, 1'b0, pat14[i]});
    run_table("s5_after", 1'b0);

    // 6: no all-red, 1-clock yellow (second instance)
    do_reset("s6", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) vecs.push_back({1'b0, 1'b0, pat10[i % 10]});
    run_table("s6_noar", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_cntr_timed.md
# tl_cntr_timed

Parametrised two-street traffic-light controller, successor to `tl_cntr`: same sensor/lamp interface, with cycle-accurate timing added. Enforces a minimum green time, a maximum green time when the cross street is waiting, a programmable yellow interval, and an optional all-red clearance interval. It sits directly on the intersection lamp drivers. Outputs are Moore-decoded from the state register only.

## Interface
- `MIN_GREEN_CYC`, 4: minimum green duration in clocks; must be ≥1.
- `MAX_GREEN_CYC`, 8: green is forced to end after this many clocks if the cross street is occupied; must be ≥ `MIN_GREEN_CYC`.
- `YELLOW_CYC`, 2: yellow duration in clocks; must be ≥1.
- `ALLRED_CYC`, 1: all-red clearance in clocks; 0 skips the all-red states.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `Ta`  in  1  traffic present on street A (synchronous to `clk`).
- `Tb`  in  1  traffic present on street B.
- `La`  out  2  street A lamp: 2'b00 GREEN, 2'b01 YELLOW, 2'b10 RED.
- `Lb`  out  2  street B lamp, same encoding.

## Operation
- States: S_AG (A green, B red), S_AY (A yellow, B red), S_AR (both red), S_BG, S_BY, S_BR (both red).
- Phase counter `cnt`: cleared to 0 on every state change. Increments each clock while the state holds. Saturates at its maximum. Width is a localparam, `$clog2(max(MAX_GREEN_CYC, YELLOW_CYC, ALLRED_CYC)+1)`.
- S_AG → S_AY when (`cnt` ≥ `MIN_GREEN_CYC`-1 and !`Ta`) or (`cnt` ≥ `MAX_GREEN_CYC`-1 and `Tb`). Otherwise it holds. With `Ta`=1 and `Tb`=0 it holds indefinitely.
- S_AY → S_AR when `cnt` = `YELLOW_CYC`-1. If `ALLRED_CYC`=0, it goes to S_BG instead.
- S_AR → S_BG when `cnt` = `ALLRED_CYC`-1.
- S_BG, S_BY and S_BR are the mirror of the A states, with `Ta` and `Tb` swapped. S_BR goes to S_AG.
- Both exit conditions true on the same cycle: transition once, to yellow.
- Lamp decode:
  - AG: La=00, Lb=10.
  - AY: La=01, Lb=10.
  - AR and BR: La=10, Lb=10.
  - BG: La=10, Lb=00.
  - BY: La=10, Lb=01.
- Both lamps are never non-RED simultaneously. Any unreachable state encoding recovers to S_AG on the next clock.

## Timing
- Reset (asynchronous assert, any state, mid-phase included): state=S_AG, `cnt`=0, and immediately La=2'b00, Lb=2'b10.
- Reset release is synchronous in effect: the first evaluation occurs at the first rising edge with `reset_n`=1.
- Inputs are sampled at the rising edge. Lamps change on that same edge, so there is 1 clock of latency from the input change to the lamp change.
- A green lasts at least `MIN_GREEN_CYC` clocks and at most `MAX_GREEN_CYC` clocks while the cross street is waiting.
- Yellow lasts exactly `YELLOW_CYC` clocks. All-red lasts exactly `ALLRED_CYC` clocks.
- With `Ta`=`Tb`=0 the controller cycles: each green lasts `MIN_GREEN_CYC` clocks, followed by yellow and all-red.
- Input glitches within a clock period have no effect. Inputs are assumed already synchronised.

## Structure
- Shared package `tl_pkg`: lamp encoding constants (GREEN, YELLOW, RED) and the state enum typedef. These are shared with `tl_cntr` and the benches.
- One sub-module, `tl_phase_timer`. It holds the counter, with a `clr` input and a saturating `cnt` output. The FSM and lamp decode stay in the top module.
- Parameter legality is checked by an elaboration-time assertion.

## Test plan
All scenarios use the default parameters and a 4 ns clock, except scenario 6.
1. `reset_n`=0 with `Ta`=0, `Tb`=1 → La=00, Lb=10 asynchronously. Release with `Ta`=1, `Tb`=0 for 20 clocks → La stays 00.
2. After reset, drop `Ta`=0 one clock after release, with `Tb`=0 → La=00 for exactly 4 clocks, then La=01 for 2 clocks, then both 10 for 1 clock, then Lb=00.
3. `Ta`=`Tb`=1 held → greens alternate, each exactly 8 clocks, separated by 2 yellow and 1 all-red clock. The sequence repeats for 3 full cycles.
4. `Ta`=`Tb`=0 held → period of 14 clocks: AG 4, AY 2, AR 1, BG 4, BY 2, BR 1.
5. Assert `reset_n`=0 during the second clock of S_BY → La=00 and Lb=10 before the next edge. After release, A green lasts the full 4-clock minimum.
6. Instance with `ALLRED_CYC`=0 and `YELLOW_CYC`=1 → the clock after AY is BG directly. No cycle ever shows both lamps RED.
